// File: rtl/multicycle_control_if.sv
// Control-unit boundary: instruction fields and flags in, datapath selects,
// enables and memory handshake out.
interface multicycle_control_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req;
    logic [1:0]  Immsrc;
    logic        PCWrite;
    logic        AdrSrc;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic        halted;
    logic [31:0] retired;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output mem_req, Immsrc, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, halted, retired
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  mem_req, Immsrc, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, halted, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control unit: per-instruction FSM driving datapath
// selects/enables, stalling on the memory ready/request handshake.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 -> PC when memory ready
// DECODE | compute branch target into ALUOut
// MEMADR | rs1 + imm -> ALUOut (load/store address)
// MEMRD  | load access at ALUOut
// MEMWB  | ReadData -> rd
// MEMWR  | store access at ALUOut
// EXEC_R | rs1 op rs2
// EXEC_I | rs1 op imm
// ALUWB  | ALUOut -> rd
// BRANCH | compare rs1/rs2, take target on beq/bne condition
// JAL    | target -> PC, PC+4 into ALUOut
// TRAP   | illegal instruction, parked until reset
module multicycle_control (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t      state_q, state_d;
    logic [31:0] retired_q;
    logic [2:0]  funct_alu;
    logic        funct_ok;
    logic        retire;

    logic       mem_req_c, pc_write_c, adr_src_c, ir_write_c, mem_write_c, reg_write_c;
    logic [1:0] result_src_c, src_a_c, src_b_c;
    logic [2:0] alu_c;

    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (bus.funct3)
            3'b000:  funct_alu = (bus.funct7b5 && bus.op[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = 2'b00;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        alu_c        = ALU_ADD;
        case (state_q)
            FETCH: begin
                mem_req_c    = 1'b1;
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                src_a_c = 2'b01;
                src_b_c = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXEC_R;
                    7'b0010011:             state_d = EXEC_I;
                    7'b1100011:             state_d = BRANCH;
                    7'b1101111:             state_d = JAL;
                    default:                state_d = TRAP;
                endcase
            end
            MEMADR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
                state_d = bus.op[5] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (bus.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = bus.mem_ready;
                if (bus.mem_ready) state_d = FETCH;
            end
            EXEC_R, EXEC_I: begin
                src_a_c = 2'b10;
                src_b_c = (state_q == EXEC_I) ? 2'b01 : 2'b00;
                alu_c   = funct_alu;
                state_d = funct_ok ? ALUWB : TRAP;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                src_a_c    = 2'b10;
                alu_c      = ALU_SUB;
                pc_write_c = bus.Zero ^ bus.funct3[0];
                state_d    = FETCH;
            end
            JAL: begin
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = ALUWB;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Every instruction-ending state returns to FETCH; MEMWR only once the store lands.
    assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH)
                 || ((state_q == MEMWR) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + 32'd1;
        end
    end

    // State already reads FETCH during reset; gating keeps memory and write strobes quiet.
    assign bus.mem_req    = mem_req_c   & rst_n;
    assign bus.PCWrite    = pc_write_c  & rst_n;
    assign bus.IRWrite    = ir_write_c  & rst_n;
    assign bus.MemWrite   = mem_write_c & rst_n;
    assign bus.RegWrite   = reg_write_c & rst_n;
    assign bus.AdrSrc     = adr_src_c;
    assign bus.ResultSrc  = result_src_c;
    assign bus.ALUSrcA    = src_a_c;
    assign bus.ALUSrcB    = src_b_c;
    assign bus.ALUControl = alu_c;
    assign bus.halted     = (state_q == TRAP);
    assign bus.retired    = retired_q;

    always_comb begin
        case (bus.op)
            7'b0100011: bus.Immsrc = 2'b01;
            7'b1100011: bus.Immsrc = 2'b10;
            7'b1101111: bus.Immsrc = 2'b11;
            default:    bus.Immsrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expectations from a small
// reference model are queued at issue and compared when the instruction retires.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if bus ();
    multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int          cycles;
        int          regwr;
        logic [1:0]  rsrc;
        int          memwr;
        int          pcwr;
        logic [2:0]  alu;
        logic [1:0]  imm;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_ret = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] model_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (f7 && op[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic z, input int sf, input int sd);
        exp_t e;
        e.rsrc = 2'b00; e.memwr = 0; e.pcwr = 1; e.regwr = 1; e.alu = 3'b111; e.imm = 2'b00;
        case (op)
            7'b0000011: begin e.cycles = 5; e.rsrc = 2'b01; e.alu = 3'b000; end
            7'b0100011: begin e.cycles = 4; e.regwr = 0; e.memwr = 1; e.alu = 3'b000; e.imm = 2'b01; end
            7'b0110011,
            7'b0010011: begin e.cycles = 4; e.alu = model_alu(op, f3, f7); end
            7'b1100011: begin e.cycles = 3; e.regwr = 0; e.alu = 3'b001; e.imm = 2'b10;
                              e.pcwr = 1 + int'(z ^ f3[0]); end
            default:    begin e.cycles = 4; e.pcwr = 2; e.imm = 2'b11; end
        endcase
        e.cycles += sf + sd;
        e.ret = exp_ret + 32'd1;
        return e;
    endfunction

    // Starts just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int sf, input int sd);
        exp_t        e;
        logic [31:0] old_ret;
        int          cyc = 0, rw = 0, mw = 0, pw = 0, stall_bad = 0;
        logic [1:0]  rsrc = 2'b11, imm = 2'b00;
        logic [2:0]  alu = 3'b111;
        logic        done = 1'b0;
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        sb_q.push_back(model(op, f3, f7, z, sf, sd));
        old_ret = bus.retired;
        while (!done && cyc < 60) begin
            @(negedge clk);
            if (bus.mem_req && !bus.AdrSrc && sf > 0) begin bus.mem_ready = 1'b0; sf--; end
            else if (bus.mem_req && bus.AdrSrc && sd > 0) begin bus.mem_ready = 1'b0; sd--; end
            else bus.mem_ready = 1'b1;
            #1;
            cyc++;
            if (bus.RegWrite) begin rw++; rsrc = bus.ResultSrc; end
            if (bus.MemWrite) mw++;
            if (bus.PCWrite) pw++;
            if (bus.ALUSrcA == 2'b10) alu = bus.ALUControl;
            imm = bus.Immsrc;
            if (!bus.mem_ready && (bus.PCWrite || bus.IRWrite || bus.MemWrite)) stall_bad++;
            @(posedge clk); #1;
            if (bus.retired != old_ret) done = 1'b1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        e = sb_q.pop_front();
        check({tag, "_cycles"}, cyc, e.cycles);
        check({tag, "_regwr"}, rw, e.regwr);
        if (e.regwr > 0) check({tag, "_rsrc"}, 32'(rsrc), 32'(e.rsrc));
        check({tag, "_memwr"}, mw, e.memwr);
        check({tag, "_pcwr"}, pw, e.pcwr);
        check({tag, "_alu"}, 32'(alu), 32'(e.alu));
        check({tag, "_imm"}, 32'(imm), 32'(e.imm));
        check({tag, "_stall"}, stall_bad, 0);
        check({tag, "_retired"}, bus.retired, e.ret);
        exp_ret = e.ret;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); bus.mem_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; bus.mem_ready = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_ret = 32'd0;
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        #1;
        check("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
        check("rst_irwrite", 32'(bus.IRWrite), 32'd0);
        check("rst_memreq", 32'(bus.mem_req), 32'd0);
        check("rst_retired", bus.retired, 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        bus.mem_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_memreq", 32'(bus.mem_req), 32'd1);
        check("rel_adrsrc", 32'(bus.AdrSrc), 32'd0);
        @(posedge clk); #1;

        run_instr("add",  7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr("beq",  7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("bne",  7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
        run_instr("bnet", 7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);
        run_instr("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("ori",  7'b0010011, 3'b110, 1'b1, 1'b0, 2, 0);
        run_instr("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("slt",  7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr("and",  7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);
        run_instr("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 1, 2);

        // Reset while a store is landing.
        bus.op = 7'b0100011; bus.funct3 = 3'b010;
        bad = 1;
        for (int i = 0; i < 10 && bad != 0; i++) begin
            @(negedge clk); bus.mem_ready = 1'b1; #1;
            if (bus.MemWrite) bad = 0;
            else begin @(posedge clk); #1; end
        end
        check("midwr_reached", bad, 0);
        rst_n = 1'b0; #1;
        check("midwr_memwrite", 32'(bus.MemWrite), 32'd0);
        check("midwr_retired", bus.retired, 32'd0);
        check("midwr_memreq", 32'(bus.mem_req), 32'd0);
        bus.mem_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        check("post_memreq", 32'(bus.mem_req), 32'd1);
        check("post_adrsrc", 32'(bus.AdrSrc), 32'd0);
        @(posedge clk); #1;
        check("post_retired", bus.retired, 32'd0);
        exp_ret = 32'd0;

        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        exp_ret = 32'hFFFF_FFFF;
        run_instr("wrap_sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0);

        // Unsupported funct3 on an R-type traps after EXEC.
        do_reset;
        bus.op = 7'b0110011; bus.funct3 = 3'b001; bus.funct7b5 = 1'b0;
        step(3);
        check("badf3_halted", 32'(bus.halted), 32'd1);
        check("badf3_retired", bus.retired, 32'd0);

        do_reset;
        bus.op = 7'b1111111; bus.funct3 = 3'b000;
        step(1);
        check("illop_decode_halted", 32'(bus.halted), 32'd0);
        step(1);
        check("illop_halted", 32'(bus.halted), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); bus.mem_ready = 1'(i % 2); #1;
            if (bus.mem_req || bus.PCWrite || bus.IRWrite || bus.MemWrite || bus.RegWrite || !bus.halted)
                bad++;
        end
        check("illop_quiet_cycles", bad, 0);
        check("illop_retired", bus.retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
